// File: rtl/mux_serial_sub_ctrl.sv
// mux_serial_sub_ctrl
//   Bit-serial WIDTH-bit subtracter A - B, LSB first, one bit per clock.
//   The full-subtracter truth table lives in two external 8:1 muxes: a
//   difference mux and a borrow mux. This controller drives their shared
//   selects and accumulates what they return.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              request, sampled only in IDLE or DONE
//   op_a, op_b         minuend / subtrahend, latched when start is accepted
//   sel_a/sel_b/sel_c  mux selects (MSB..LSB) = a bit, b bit, running borrow
//   mux_diff           difference mux output
//   mux_borrow         borrow mux output
//   busy               high while the subtraction is running
//   done               one-cycle pulse when diff/borrow_out are updated
//   diff, borrow_out   registered result; borrow_out=1 means op_a < op_b
module mux_serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  input  logic             mux_diff,
  input  logic             mux_borrow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic             run;
  logic [IDX_W-1:0] bit_idx;

  assign run     = (state_q == ST_RUN);
  assign bit_idx = idx_q[IDX_W-1:0];

  // Selects are gated so the muxes see a quiet 000 outside RUN.
  assign sel_a      = run & a_q[bit_idx];
  assign sel_b      = run & b_q[bit_idx];
  assign sel_c      = run & brw_q;
  assign busy       = run;
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    brw_d        = brw_q;
    idx_d        = idx_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new start directly so back-to-back requests
        // incur no idle bubble.
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
          brw_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[bit_idx] = mux_diff;
        brw_d          = mux_borrow;
        idx_d          = idx_q + CNT_W'(1);
        if (idx_q == LAST_IDX) begin
          // The top bit arrives on this edge, so merge it straight into
          // the result rather than waiting a cycle for acc to settle.
          diff_d              = acc_q;
          diff_d[WIDTH-1]     = mux_diff;
          borrow_out_d        = mux_borrow;
          state_d             = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      brw_q        <= 1'b0;
      idx_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      brw_q        <= brw_d;
      idx_q        <= idx_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

endmodule

// File: tb/tb_mux_serial_sub_ctrl.sv
// Testbench for mux_serial_sub_ctrl: models the two 8:1 lookup muxes,
// drives directed operand pairs and checks results through a scoreboard.
module tb_mux_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       sel_a, sel_b, sel_c;
  logic       mux_diff, mux_borrow;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow_out;

  mux_serial_sub_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .sel_c      (sel_c),
    .mux_diff   (mux_diff),
    .mux_borrow (mux_borrow),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External mux pair: y0..y7 data patterns, select = {a,b,c}.
  // Outside RUN the muxes return noise, which must never be captured.
  logic [7:0] dpat, bpat;
  logic       noise_d, noise_b;
  initial begin
    dpat = 8'b1001_0110;
    bpat = 8'b1000_1110;
    noise_d = 1'b0;
    noise_b = 1'b0;
  end
  always #3 begin
    noise_d = 1'($urandom);
    noise_b = 1'($urandom);
  end
  assign mux_diff   = busy ? dpat[{sel_a, sel_b, sel_c}] : noise_d;
  assign mux_borrow = busy ? bpat[{sel_a, sel_b, sel_c}] : noise_b;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t       pend[$];
  logic [8:0] sb[$];    // {borrow_out, diff}
  int         errors = 0;
  int         checks = 0;
  int         dcount = 0;
  int         cyc = 0;
  int         busy_tot = 0;
  int         c0, b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (busy) busy_tot++;

  // Single checker process: drains posted direct checks and compares every
  // done pulse against the scoreboard head.
  always @(negedge clk) begin
    while (pend.size() > 0) begin
      chk_t c;
      c = pend.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
      end
    end
    if (!rst_n) sb.delete();
    else if (done) begin
      dcount++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got diff=%0h borrow=%0b expected no done", diff, borrow_out);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({borrow_out, diff} !== e) begin
          errors++;
          $display("FAIL result: got diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                   diff, borrow_out, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
    pend.push_back('{n, a, e});
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic hold);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    sb.push_back({eb, ed});
    c0 = cyc;
    b0 = busy_tot;
  endtask

  task automatic finish_op(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    post({tag, "_done_seen"}, 32'(seen), 32'd1);
    post({tag, "_latency"}, 32'(cyc - c0 + 1), 32'd9);
    post({tag, "_busy_cycles"}, 32'(busy_tot - b0), 32'd8);
    @(posedge clk); #1;
    post({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    post("reset_diff", 32'(diff), 32'd0);
    post("reset_borrow", 32'(borrow_out), 32'd0);
    post("reset_busy", 32'(busy), 32'd0);
    post("reset_done", 32'(done), 32'd0);
    post("reset_sel", 32'({sel_a, sel_b, sel_c}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 - 3: also walk the first three select triples.
    accept(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    post("sel_step0", 32'({sel_a, sel_b, sel_c}), 32'b110);
    @(posedge clk); #1;
    post("sel_step1", 32'({sel_a, sel_b, sel_c}), 32'b010);
    @(posedge clk); #1;
    post("sel_step2", 32'({sel_a, sel_b, sel_c}), 32'b101);
    finish_op("t5m3");

    // 3 - 5 with a start pulse mid-RUN that must be ignored.
    accept(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    op_a  = 8'h77;
    op_b  = 8'h11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("t3m5");

    accept(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    finish_op("t0m1");

    // Reset at idx=4 of a run; this run's result must never appear.
    accept(8'h10, 8'h00, 8'h10, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    post("pre_rst_sel_a", 32'(sel_a), 32'd1);
    post("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    post("rst_diff", 32'(diff), 32'd0);
    post("rst_borrow", 32'(borrow_out), 32'd0);
    post("rst_busy", 32'(busy), 32'd0);
    post("rst_done", 32'(done), 32'd0);
    post("rst_sel", 32'({sel_a, sel_b, sel_c}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    post("post_rst_busy", 32'(busy), 32'd0);
    post("post_rst_done", 32'(done), 32'd0);

    accept(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    finish_op("tffmff");

    // Back-to-back: start held through DONE with the next operands.
    accept(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);
    op_a = 8'h10;
    op_b = 8'h01;
    sb.push_back({1'b0, 8'h0F});
    finish_op("t80m7f");
    post("b2b_no_bubble", 32'(busy), 32'd1);
    c0 = cyc;
    b0 = busy_tot;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    post("b2b_diff_held", 32'(diff), 32'h01);
    finish_op("t10m01");

    post("sb_empty", 32'(sb.size()), 32'd0);
    post("done_count", 32'(dcount), 32'd6);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_serial_sub_ctrl.md
Name: mux_serial_sub_ctrl

Overview:
- Sequencer that performs a WIDTH-bit subtraction A − B, LSB first, one bit per clock.
- It reuses two external 8:1 mux instances as a full-subtracter lookup:
  - difference mux, data pattern 0,1,1,0,1,0,0,1 on y0..y7;
  - borrow mux, data pattern 0,1,1,1,0,0,0,1 on y0..y7.
- The controller drives the shared select lines (a_bit, b_bit, borrow) and captures both mux outputs every cycle. It accumulates the result and the final borrow.
- It sits between a requesting unit (start/operands) and the combinational mux pair.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, width of the internal bit-index counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op_a  input  WIDTH  minuend, latched on accepted start.
- op_b  input  WIDTH  subtrahend, latched on accepted start.
- sel_a  output  1  mux select MSB = op_a bit at current index.
- sel_b  output  1  mux select middle = op_b bit at current index.
- sel_c  output  1  mux select LSB = running borrow.
- mux_diff  input  1  output of difference mux (combinational from sel_*).
- mux_borrow  input  1  output of borrow mux (combinational from sel_*).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- diff  output  WIDTH  registered result.
- borrow_out  output  1  final borrow; 1 means A < B unsigned.

Behaviour:
- Reset (async, rst_n=0) drives all outputs to 0: state=IDLE, idx=0, borrow reg=0, sel_a/b/c=0, busy=0, done=0, diff=0, borrow_out=0. Reset while RUN discards the operation immediately.
- Registers: a_reg, b_reg (WIDTH), acc (WIDTH), brw (1), idx (CNT_W), state.
- Select lines are combinational from registers:
  - sel_a = a_reg[idx], sel_b = b_reg[idx], sel_c = brw, while in RUN;
  - all three are 0 in IDLE and DONE.
- IDLE: start=1 at an edge latches op_a/op_b, sets brw=0, idx=0, acc=0, and moves to RUN. start=0 keeps IDLE.
- RUN: each edge captures acc[idx]←mux_diff and brw←mux_borrow, then idx←idx+1.
  - On the edge where idx = WIDTH−1:
    - diff←acc with bit WIDTH−1 replaced by mux_diff;
    - borrow_out←mux_borrow;
    - state←DONE.
  - start is ignored in RUN; op_a/op_b changes are ignored.
- DONE: lasts exactly one cycle with done=1 and busy=0.
  - Next edge: if start=1, accept as in IDLE (back-to-back, no idle bubble); else go to IDLE.
- Latency: start sampled at edge E0; RUN spans cycles E0..E(WIDTH); done is high in the cycle after edge E(WIDTH). That is WIDTH+1 edges from acceptance to done.
- diff/borrow_out hold their previous values through a new RUN and update only on the completing edge. They hold until the next completion or reset.
- Arithmetic: diff = (op_a − op_b) mod 2^WIDTH; borrow_out = (op_a < op_b).
- Mux outputs are sampled only in RUN; X/garbage on mux_diff/mux_borrow outside RUN must not affect any register.
- Encoding: IDLE, RUN, DONE; any illegal state recovers to IDLE on the next edge.

Test Plan:
- op_a=0x05, op_b=0x03, start pulse. Required select sequence (a,b,c), first three RUN cycles:
  - (1,1,0) → diff bit 0, borrow 0;
  - (0,1,0) → diff bit 1, borrow 1;
  - (1,0,1) → diff bit 0, borrow 0.
  - Result: done after 9 edges, diff=0x02, borrow_out=0.
- op_a=0x03, op_b=0x05 → diff=0xFE, borrow_out=1. Also op_a=0x00, op_b=0x01 → diff=0xFF, borrow_out=1.
- op_a=0xFF, op_b=0xFF → diff=0x00, borrow_out=0. op_a=0x80, op_b=0x7F → diff=0x01, borrow_out=0.
- Pulse start again mid-RUN with different operands → ignored. First result is unchanged, busy stays high for exactly 8 cycles, single done pulse.
- Back-to-back: start held high through DONE with new operands 0x10−0x01 → second RUN begins the cycle after done, diff=0x0F, no idle cycle. diff keeps the first result until the second completion.
- Assert rst_n=0 at RUN idx=4 → all outputs 0 asynchronously, before the next edge. After release, no done pulse until a new start, and the state is IDLE.
